// File: rtl/sw_reg_bank_r_pkg.sv
// Shared constants and types for the fabric-to-software register bank.
// Word offsets, CTRL/STATUS bit positions, capture modes and FSM states.
package sw_reg_pkg;

    localparam int CTRL_IDX      = 0;
    localparam int STATUS_IDX    = 1;
    localparam int DATA_BASE_IDX = 2;

    localparam int CTRL_SNAP_BIT = 0;
    localparam int CTRL_CLR_BIT  = 1;
    localparam int CTRL_FRZ_BIT  = 2;
    localparam int CTRL_BUSY_BIT = 0;

    localparam int ST_DONE_BIT   = 16;
    localparam int ST_TMO_BIT    = 17;
    localparam int ST_RTG_BIT    = 18;

    localparam int MODE_LIVE     = 0;
    localparam int MODE_SNAP     = 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/sw_reg_bank_r_if.sv
// Wishbone classic slave bundle for the register bank.
// Master drives the request, slave returns data, ack and err.
interface sw_reg_bank_r_if;

    logic        wb_cyc_i;
    logic        wb_stb_i;
    logic        wb_we_i;
    logic [3:0]  wb_sel_i;
    logic [31:0] wb_adr_i;
    logic [31:0] wb_dat_i;
    logic [31:0] wb_dat_o;
    logic        wb_ack_o;
    logic        wb_err_o;

    modport master (
        output wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        input  wb_dat_o, wb_ack_o, wb_err_o
    );

    modport slave (
        input  wb_cyc_i, wb_stb_i, wb_we_i, wb_sel_i, wb_adr_i, wb_dat_i,
        output wb_dat_o, wb_ack_o, wb_err_o
    );

endinterface

// File: rtl/sw_reg_bank_r_chan.sv
// One channel buffer with live capture enable and a snapshot pending bit.
// The pending bit is set on arm and cleared on capture or timeout drop.
module sw_reg_chan #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    input  logic         valid,
    input  logic         live_en,
    input  logic         armed,
    input  logic         arm,
    input  logic         drop,
    output logic [W-1:0] q,
    output logic         pend
);

    logic take;

    assign take = live_en ? valid : (armed & pend & valid);

    // Buffer captures on take; pending tracks channels still owed to a snapshot.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= '0;
            pend <= 1'b0;
        end else begin
            if (take) q <= d;
            if (arm) pend <= 1'b1;
            else if (drop || (armed && valid)) pend <= 1'b0;
        end
    end

endmodule

// File: rtl/sw_reg_bank_r.sv
// Multi-channel fabric-to-software read register bank on a Wishbone slave.
// LIVE mode tracks the latest valid data; SNAPSHOT mode captures coherently.
module sw_reg_bank_r
    import sw_reg_pkg::*;
#(
    parameter logic [31:0] C_BASEADDR  = 32'h0000_0000,
    parameter logic [31:0] C_HIGHADDR  = 32'h0000_00FF,
    parameter int          C_NUM_REGS  = 4,
    parameter int          C_REG_WIDTH = 32,
    parameter int          C_MODE      = 0,
    parameter int          C_TIMEOUT   = 1024
) (
    input  logic                              wb_clk_i,
    input  logic                              wb_rst_i,
    sw_reg_bank_r_if.slave                    wb,
    input  logic [C_NUM_REGS*C_REG_WIDTH-1:0] fabric_data_in,
    input  logic [C_NUM_REGS-1:0]             fabric_valid_in,
    output logic                              fabric_snap_o
);

    state_t                 state;
    logic [31:0]            timer;
    logic [15:0]            snap_cnt;
    logic                   f_done, f_tmo, f_rtg;
    logic                   freeze;
    logic                   ack_q, err_q;
    logic [31:0]            dat_q;
    logic [31:0]            off, idx, rdata;
    logic                   hit, req, is_ctrl, is_stat, ok_rd;
    logic                   ctrl_wr, snap_req, clr_req;
    logic                   busy, armed, arm, drop, all_cap, tmo_hit, live_en;
    logic [C_NUM_REGS-1:0]  pend;
    logic [C_REG_WIDTH-1:0] chan_q [C_NUM_REGS];
    logic                   unused_bits;

    assign off     = wb.wb_adr_i - C_BASEADDR;
    assign idx     = {2'b00, off[31:2]};
    assign hit     = (wb.wb_adr_i >= C_BASEADDR) && (wb.wb_adr_i <= C_HIGHADDR);
    assign req     = wb.wb_cyc_i & wb.wb_stb_i & hit & ~(ack_q | err_q);
    assign is_ctrl = (idx == 32'(CTRL_IDX));
    assign is_stat = (idx == 32'(STATUS_IDX));
    assign ok_rd   = (idx < 32'(DATA_BASE_IDX + C_NUM_REGS));
    assign ctrl_wr = req & wb.wb_we_i & is_ctrl & wb.wb_sel_i[0];
    assign snap_req = ctrl_wr & wb.wb_dat_i[CTRL_SNAP_BIT] & (C_MODE == MODE_SNAP);
    assign clr_req  = ctrl_wr & wb.wb_dat_i[CTRL_CLR_BIT];

    assign busy    = (state != IDLE);
    assign armed   = (state == ARMED);
    assign arm     = (state == IDLE) & snap_req;
    assign all_cap = &(~pend | fabric_valid_in);
    assign tmo_hit = (C_TIMEOUT != 0) && (timer + 32'd1 == 32'(C_TIMEOUT));
    assign drop    = armed & tmo_hit & ~all_cap;
    assign live_en = (C_MODE == MODE_LIVE) & ~freeze;

    assign wb.wb_ack_o = ack_q;
    assign wb.wb_err_o = err_q;
    assign wb.wb_dat_o = dat_q;

    assign unused_bits = ^{wb.wb_sel_i[3:1], wb.wb_dat_i[31:3], off[1:0]};

    for (genvar i = 0; i < C_NUM_REGS; i++) begin : g_chan
        sw_reg_chan #(.W(C_REG_WIDTH)) u_chan (
            .clk     (wb_clk_i),
            .rst_n   (wb_rst_i),
            .d       (fabric_data_in[i*C_REG_WIDTH +: C_REG_WIDTH]),
            .valid   (fabric_valid_in[i]),
            .live_en (live_en),
            .armed   (armed),
            .arm     (arm),
            .drop    (drop),
            .q       (chan_q[i]),
            .pend    (pend[i])
        );
    end

    // Read mux: CTRL, STATUS or a zero-extended channel buffer.
    always_comb begin
        rdata = '0;
        unique case (1'b1)
            is_ctrl: begin
                rdata[CTRL_BUSY_BIT] = busy;
                rdata[CTRL_FRZ_BIT]  = freeze;
            end
            is_stat: rdata = {8'(C_NUM_REGS), 5'd0, f_rtg, f_tmo, f_done, snap_cnt};
            default: begin
                for (int i = 0; i < C_NUM_REGS; i++)
                    if (idx == 32'(DATA_BASE_IDX + i)) rdata = 32'(chan_q[i]);
            end
        endcase
    end

    // Bus response: one-cycle ack or err, data only alongside ack.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            ack_q  <= 1'b0;
            err_q  <= 1'b0;
            dat_q  <= '0;
            freeze <= 1'b0;
        end else begin
            ack_q <= 1'b0;
            err_q <= 1'b0;
            dat_q <= '0;
            if (req) begin
                if (wb.wb_we_i ? is_ctrl : ok_rd) begin
                    ack_q <= 1'b1;
                    if (!wb.wb_we_i) dat_q <= rdata;
                end else begin
                    err_q <= 1'b1;
                end
            end
            if (ctrl_wr && C_MODE == MODE_LIVE) freeze <= wb.wb_dat_i[CTRL_FRZ_BIT];
        end
    end

    // Snapshot FSM with timer, counter and sticky flags; flag sets beat clears.
    always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
        if (!wb_rst_i) begin
            state         <= IDLE;
            timer         <= '0;
            snap_cnt      <= '0;
            f_done        <= 1'b0;
            f_tmo         <= 1'b0;
            f_rtg         <= 1'b0;
            fabric_snap_o <= 1'b0;
        end else begin
            fabric_snap_o <= 1'b0;
            if (clr_req) begin
                f_done <= 1'b0;
                f_tmo  <= 1'b0;
                f_rtg  <= 1'b0;
            end
            if (snap_req && busy) f_rtg <= 1'b1;
            unique case (state)
                IDLE: begin
                    if (snap_req) begin
                        state <= ARMED;
                        timer <= '0;
                    end
                end
                ARMED: begin
                    timer <= timer + 32'd1;
                    if (all_cap) begin
                        state         <= DONE;
                        fabric_snap_o <= 1'b1;
                    end else if (tmo_hit) begin
                        state <= IDLE;
                        f_tmo <= 1'b1;
                    end
                end
                DONE: begin
                    snap_cnt <= snap_cnt + 16'd1;
                    f_done   <= 1'b1;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
